// File: rtl/filter_pkg.sv
// filter_pkg: shared state encoding, default geometry and data typedefs for the filter row buffer.
package filter_pkg;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DEPTH_F_DEF    = 5;
    localparam int WIDTH_DEF      = 8;
    localparam int PACK_WIDTH_DEF = 64;
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    typedef logic [WIDTH_DEF-1:0]      weight_t;
    typedef logic [PACK_WIDTH_DEF-1:0] row_t;
endpackage

// File: rtl/filter_row_pack.sv
// filter_row_pack: packs one row of DEPTH_F weights into a zero-padded PACK_WIDTH bus (weight 0 in the low bits).
module filter_row_pack import filter_pkg::*; #(
    parameter int DEPTH_F    = DEPTH_F_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int PACK_WIDTH = PACK_WIDTH_DEF
) (
    input  logic [DEPTH_F*WIDTH-1:0] slice,
    output logic [PACK_WIDTH-1:0]    row
);
    assign row = PACK_WIDTH'(slice);
endmodule

// File: rtl/filter_row_buffer.sv
// filter_row_buffer: loads DEPTH_F*DEPTH_F addressed weights, then streams them out as DEPTH_F packed rows.
// Optional FILTER_REPLAY_EN adds a replay input that re-streams the last completed load from IDLE.
module filter_row_buffer import filter_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH_F    = DEPTH_F_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int PACK_WIDTH = PACK_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       load_done,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PACK_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH_F)-1:0] out_row,
    output logic [ADDR_WIDTH:0]        wr_count,
    output logic                       addr_err,
    output logic                       busy
`ifdef FILTER_REPLAY_EN
    ,
    input  logic                       replay
`endif
);
    localparam int RW = $clog2(DEPTH_F);
    localparam int NW = DEPTH_F * DEPTH_F;
    localparam int RB = DEPTH_F * WIDTH;
    localparam logic [RW-1:0]       LAST_ROW = RW'(DEPTH_F - 1);
    localparam logic [ADDR_WIDTH:0] NW_L     = (ADDR_WIDTH + 1)'(NW);

    state_t state, state_nx;
    logic [NW*WIDTH-1:0] wbits;
    logic [PACK_WIDTH-1:0] packed_row;
    logic do_replay, clear, addr_ok;

`ifdef FILTER_REPLAY_EN
    logic loaded;
    always_ff @(posedge clk or posedge rst)
        if (rst) loaded <= 1'b0;
        else if (state == LOAD && load_done && !load_start) loaded <= 1'b1;
    assign do_replay = replay && loaded;
`else
    assign do_replay = 1'b0;
`endif

    assign clear     = load_start && state != SEND;
    assign addr_ok   = {1'b0, wr_addr} < NW_L;
    assign wr_ready  = state == LOAD;
    assign out_valid = state == SEND;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = (state == IDLE) ? (load_start ? LOAD : do_replay ? SEND : IDLE)
                 : (state == LOAD) ? ((load_done && !load_start) ? SEND : LOAD)
                 : (out_ready && out_row == LAST_ROW) ? IDLE : SEND;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    // A restart in LOAD wins over a same-cycle write, which is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbits    <= '0;
            wr_count <= '0;
            addr_err <= 1'b0;
            out_row  <= '0;
        end else begin
            if (clear) begin
                wbits    <= '0;
                wr_count <= '0;
                addr_err <= 1'b0;
            end else if (state == LOAD && wr_valid) begin
                if (addr_ok) begin
                    wbits[wr_addr*WIDTH +: WIDTH] <= wr_data;
                    wr_count <= (wr_count == '1) ? wr_count : wr_count + 1'b1;
                end else begin
                    addr_err <= 1'b1;
                end
            end
            if (state == SEND && out_ready)
                out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
        end
    end

    filter_row_pack #(.DEPTH_F(DEPTH_F), .WIDTH(WIDTH), .PACK_WIDTH(PACK_WIDTH)) u_pack (
        .slice(wbits[out_row*RB +: RB]),
        .row  (packed_row)
    );

    assign out_data = out_valid ? packed_row : '0;
endmodule

// File: tb/tb_filter_row_buffer.sv
// tb_filter_row_buffer: directed and randomized load/stream traffic checked every cycle against a behavioural model.
module tb_filter_row_buffer;
    logic clk = 1'b0, rst = 1'b1;
    logic ls = 1'b0, ld = 1'b0, wv = 1'b0, ordy = 1'b0;
    logic [4:0] wa = '0;
    logic [7:0] wd = '0;
`ifdef FILTER_REPLAY_EN
    logic rp = 1'b0;
`endif
    logic wr_ready, out_valid, addr_err, busy;
    logic [63:0] out_data;
    logic [2:0] out_row;
    logic [5:0] wr_count;
    int checks = 0, failures = 0;
    logic [63:0] lit [5] = '{64'h0504030201, 64'h0A09080706, 64'h0F0E0D0C0B, 64'h1413121110, 64'h1918171615};

    filter_row_buffer dut (
        .clk(clk), .rst(rst), .load_start(ls), .load_done(ld), .wr_valid(wv), .wr_ready(wr_ready),
        .wr_addr(wa), .wr_data(wd), .out_valid(out_valid), .out_ready(ordy), .out_data(out_data),
        .out_row(out_row), .wr_count(wr_count), .addr_err(addr_err), .busy(busy)
`ifdef FILTER_REPLAY_EN
        , .replay(rp)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 loading, 2 sending.
    int ms = 0, mcnt = 0, mrow = 0;
    int mw [25];
    bit merr = 1'b0;
`ifdef FILTER_REPLAY_EN
    bit mloaded = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms <= 0; mcnt <= 0; mrow <= 0; merr <= 1'b0;
            foreach (mw[i]) mw[i] <= 0;
`ifdef FILTER_REPLAY_EN
            mloaded <= 1'b0;
`endif
        end else if (ms == 0) begin
            if (ls) begin
                ms <= 1; mcnt <= 0; merr <= 1'b0;
                foreach (mw[i]) mw[i] <= 0;
            end
`ifdef FILTER_REPLAY_EN
            else if (rp && mloaded) begin ms <= 2; mrow <= 0; end
`endif
        end else if (ms == 1) begin
            if (ls) begin
                mcnt <= 0; merr <= 1'b0;
                foreach (mw[i]) mw[i] <= 0;
            end else begin
                if (wv) begin
                    if (int'(wa) < 25) begin
                        mw[wa] <= int'(wd);
                        mcnt <= (mcnt < 63) ? mcnt + 1 : 63;
                    end else merr <= 1'b1;
                end
                if (ld) begin
                    ms <= 2; mrow <= 0;
`ifdef FILTER_REPLAY_EN
                    mloaded <= 1'b1;
`endif
                end
            end
        end else if (ordy) begin
            if (mrow == 4) begin ms <= 0; mrow <= 0; end
            else mrow <= mrow + 1;
        end
    end

    function automatic logic [63:0] exp_row(int r);
        logic [63:0] v = '0;
        for (int c = 0; c < 5; c++) v |= 64'(mw[r*5 + c]) << (8*c);
        return v;
    endfunction

    always @(negedge clk) begin
        chk("wr_ready", wr_ready, 64'(ms == 1));
        chk("busy", busy, 64'(ms != 0));
        chk("out_valid", out_valid, 64'(ms == 2));
        chk("wr_count", wr_count, 64'(mcnt));
        chk("addr_err", addr_err, 64'(merr));
        chk("out_data", out_data, ms == 2 ? exp_row(mrow) : 64'd0);
        if (ms == 2) chk("out_row", out_row, 64'(mrow));
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic start(); ls = 1'b1; step(); ls = 1'b0; endtask
    task automatic wr(int a, int d); wv = 1'b1; wa = 5'(a); wd = 8'(d); step(); wv = 1'b0; endtask
    task automatic finish_load(); ld = 1'b1; step(); ld = 1'b0; endtask
    task automatic load_seq(); start(); for (int i = 0; i < 25; i++) wr(i, i + 1); endtask
    task automatic drain();
        ordy = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++) step();
        chk("drain_done", out_valid, 0);
    endtask

    initial begin
        int hs;
        logic [3:0] pat = 4'b1001;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_wr_count", wr_count, 0);
        rst = 1'b0;
        step();
        // full load, back-to-back drain
        load_seq();
        chk("t1_cnt", wr_count, 25);
        chk("t1_pre_valid", out_valid, 0);
        ordy = 1'b1;
        finish_load();
        chk("t1_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            chk("t1_row", out_data, lit[k]);
            chk("t1_idx", out_row, 64'(k));
            step();
        end
        chk("t1_idle", busy, 0);
        // stalled drain
        load_seq();
        ordy = 1'b0;
        finish_load();
        hs = 0;
        for (int p = 0; p < 100 && out_valid; p++) begin
            ordy = pat[p % 4];
            if (ordy) begin
                chk("t2_row", out_data, hs < 5 ? lit[hs] : 64'd0);
                hs++;
            end
            step();
        end
        chk("t2_hs", 64'(hs), 5);
        chk("t2_idle", busy, 0);
        // single weight
        start();
        wr(7, 'hAB);
        chk("t3_cnt", wr_count, 1);
        ordy = 1'b1;
        finish_load();
        for (int k = 0; k < 5; k++) begin
            chk("t3_row", out_data, k == 1 ? 64'h0000AB0000 : 64'd0);
            step();
        end
        // out-of-range address
        start();
        wr(30, 'hFF);
        chk("t4_err", addr_err, 1);
        chk("t4_cnt", wr_count, 0);
        start();
        chk("t4_err_clr", addr_err, 0);
        finish_load();
        drain();
        // reset mid-send
        load_seq();
        ordy = 1'b1;
        finish_load();
        step(); step();
        chk("t5_row_idx", out_row, 2);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        start();
        for (int i = 10; i < 15; i++) wr(i, 'hC0 + i);
        finish_load();
        for (int k = 0; k < 5; k++) begin
            chk("t5_row", out_data, k == 2 ? 64'hCECDCCCBCA : 64'd0);
            step();
        end
        // write coincident with load_done
        start();
        for (int i = 0; i < 24; i++) wr(i, $urandom_range(0, 255));
        wv = 1'b1; wa = 5'd24; wd = 8'h33; ld = 1'b1;
        step();
        wv = 1'b0; ld = 1'b0; ordy = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("t6_idx", out_row, 4);
        chk("t6_top", out_data[39:32], 'h33);
        step();
`ifdef FILTER_REPLAY_EN
        rp = 1'b1;
        step();
        rp = 1'b0;
        chk("rp_valid", out_valid, 1);
        for (int k = 0; k < 4; k++) step();
        chk("rp_top", out_data[39:32], 'h33);
        drain();
`endif
        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            for (int n = $urandom_range(0, 3); n > 0; n--) begin
                wv = 1'($urandom); ld = 1'($urandom); wa = 5'($urandom); wd = 8'($urandom);
                step();
            end
            wv = 1'b0; ld = 1'b0;
            start();
            for (int n = $urandom_range(0, 30); n > 0; n--) begin
                wv = 1'($urandom); wa = 5'($urandom); wd = 8'($urandom);
                ls = ($urandom_range(0, 15) == 0);
                step();
            end
            ls = 1'b0; wv = 1'($urandom); wa = 5'($urandom); wd = 8'($urandom);
            finish_load();
            wv = 1'b0;
            for (int n = 0; n < 60 && busy; n++) begin
                ordy = 1'($urandom);
                ls = ($urandom_range(0, 7) == 0);
                ld = ($urandom_range(0, 7) == 0);
                wv = 1'($urandom); wa = 5'($urandom); wd = 8'($urandom);
                step();
            end
            ls = 1'b0; ld = 1'b0; wv = 1'b0;
            chk("rnd_end", busy, 0);
        end
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/filter_row_buffer.md
Name: filter_row_buffer

Overview:
Clocked receiver for the filter-load protocol: accepts a load_start marker, DEPTH_F*DEPTH_F addressed weight writes and a load_done marker, then streams the filter back out as DEPTH_F packed rows.
Sits between the filter-load source (host/testbench or DMA) and the PE array that consumes one packed filter row per transfer.
Replaces the CSP channel handshakes of the behavioural filter memory with synchronous valid/ready signalling.

Parameters:
ADDR_WIDTH, 5, width of weight address (must satisfy 2^ADDR_WIDTH >= DEPTH_F*DEPTH_F)
DEPTH_F, 5, filter dimension; DEPTH_F*DEPTH_F weights, DEPTH_F rows
WIDTH, 8, bits per weight
PACK_WIDTH, 64, output row bus width (must satisfy PACK_WIDTH >= DEPTH_F*WIDTH)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
load_start  in  1  single-cycle pulse; begins a load
load_done  in  1  single-cycle pulse; ends a load
wr_valid  in  1  weight write request
wr_ready  out  1  buffer accepts writes (high only in LOAD)
wr_addr  in  ADDR_WIDTH  weight index, row-major (addr = row*DEPTH_F + col)
wr_data  in  WIDTH  weight value
out_valid  out  1  packed row available
out_ready  in  1  consumer accepts row
out_data  out  PACK_WIDTH  packed row
out_row  out  $clog2(DEPTH_F)  index of row on out_data
wr_count  out  ADDR_WIDTH+1  writes accepted in current load
addr_err  out  1  sticky; an out-of-range address was seen in current load
busy  out  1  high in LOAD or SEND
replay  in  1  only when FILTER_REPLAY_EN is defined (see Optional Feature)

Behaviour:
- Reset (async assert, sync use after release): state IDLE; all weights 0; wr_ready=0, out_valid=0, out_data=0, out_row=0, wr_count=0, addr_err=0, busy=0. Reset mid-load or mid-send aborts immediately; no partial row is emitted afterwards.
- States: IDLE, LOAD, SEND.
- IDLE: wr_ready=0; wr_valid ignored; load_done ignored. load_start -> LOAD next cycle; on that edge clear all weights to 0, wr_count=0, addr_err=0.
- LOAD: wr_ready=1. A write is accepted on a cycle with wr_valid&wr_ready.
  - addr < DEPTH_F*DEPTH_F: weight[addr] <= wr_data; wr_count++ (saturates at 2^(ADDR_WIDTH+1)-1). Rewriting an address overwrites; it still counts.
  - addr >= DEPTH_F*DEPTH_F: data dropped, wr_count unchanged, addr_err <= 1.
  - load_start in LOAD: restart (clear weights, counters, err); a write in the same cycle is discarded.
  - load_done in LOAD: -> SEND. A write in the same cycle is accepted first and is visible in the rows.
  - Unwritten weights read as 0.
- SEND: wr_ready=0. out_valid rises the cycle after load_done is accepted (1-cycle latency); out_row=0.
  - out_data[c*WIDTH +: WIDTH] = weight[out_row*DEPTH_F + c] for c=0..DEPTH_F-1; bits above DEPTH_F*WIDTH are 0.
  - out_valid&out_ready: advance out_row next cycle. out_valid stays high (back-to-back, 1 row/cycle max). out_data/out_row are stable while out_valid&!out_ready.
  - Handshake on row DEPTH_F-1: out_valid=0 next cycle, -> IDLE. Weights, wr_count and addr_err are retained until the next load_start.
  - load_start and load_done in SEND are ignored.
- busy = (state != IDLE).

Optional Feature:
FILTER_REPLAY_EN: when defined, the replay input exists. A replay pulse in IDLE, after at least one completed load, enters SEND with out_row=0 and re-streams the retained weights with identical timing. Replay is ignored in LOAD and SEND. When not defined, the port is absent and filters must be reloaded to resend.

Decomposition:
- Package filter_pkg: state enum (IDLE/LOAD/SEND), DEPTH_F/WIDTH/PACK_WIDTH defaults, weight typedef logic [WIDTH-1:0], row typedef logic [PACK_WIDTH-1:0].
- One sub-module filter_row_pack: combinational DEPTH_F-weight slice -> zero-padded packed row, reused by the PE-side unpacker's checker.

Test Plan:
- Load weights 1..25 to addrs 0..24, load_done, out_ready=1 -> rows 0x0504030201, 0x0A09080706, ... 0x1918171615 on 5 consecutive cycles; out_valid first high 1 cycle after load_done; wr_count=25.
- Same load with out_ready toggling 1,0,0,1... -> each row held stable while stalled; no row lost or duplicated; 5 handshakes total, then IDLE.
- Write only addr 7 = 0xAB, then load_done -> row1 = 0x0000AB0000, all other rows 0, wr_count=1.
- Write to addr 30 with 0xFF during load -> addr_err=1, no row changed, wr_count unchanged; next load_start clears addr_err.
- Assert rst during SEND after row 2 -> next cycle out_valid=0, busy=0; after reload, rows reflect only the new data.
- wr_valid with addr 24 = 0x33 in the same cycle as load_done -> row4 top byte = 0x33. With FILTER_REPLAY_EN: replay pulse in IDLE -> same 5 rows re-sent.
